ramp_counter_ctrl: RTL and testbench

- Parametrised successor of the fixed 8-bit sawtooth counter control path.
- One block holds the tick divider, the N1/N2 load FSM and a W-bit ramp generator.
- The ramp runs in sawtooth or triangle mode between min(N1,N2) and max(N1,N2), with a freeze state and a wrap pulse.
- Outputs drive LED/seven-segment decoders and the debug state display at top level.

---
 rtl/ramp_counter_ctrl.sv | 200 ++++++++++++++++++++
 tb/tb_ramp_counter_ctrl.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ramp_counter_ctrl.sv
// ramp_counter_ctrl: tick divider, N1/N2 load FSM and W-bit ramp generator.
// The ramp runs between min(N1,N2) and max(N1,N2) in sawtooth or triangle mode.
//
// Optional feature macro: DEBOUNCE_EN (debounce filter on the synchronised v_i).
//
// Ports:
//   clk_i    system clock
//   rst_i    synchronous reset, active-low
//   v_i      select button, asynchronous level
//   din_i    N1/N2 data input (W bits)
//   mode_i   0 = sawtooth, 1 = triangle; latched on RUN entry
//   cnt_o    ramp counter value
//   n1_o     captured N1
//   n2_o     captured N2
//   dind_o   indication value (combinational: din_i while loading, cnt_o otherwise)
//   state_o  FSM state code
//   tick_o   one-cycle divider tick
//   wrap_o   one-cycle wrap/period pulse
module ramp_counter_ctrl #(
    parameter int unsigned W       = 8,
    parameter int unsigned DIV     = 12500000,
    parameter int unsigned DEB_CYC = 500000
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         v_i,
    input  logic [W-1:0] din_i,
    input  logic         mode_i,
    output logic [W-1:0] cnt_o,
    output logic [W-1:0] n1_o,
    output logic [W-1:0] n2_o,
    output logic [W-1:0] dind_o,
    output logic [1:0]   state_o,
    output logic         tick_o,
    output logic         wrap_o
);

    localparam int unsigned      DIV_W    = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);

    typedef enum logic [1:0] {
        S_LOAD_N1 = 2'd0,
        S_LOAD_N2 = 2'd1,
        S_RUN     = 2'd2,
        S_HOLD    = 2'd3
    } state_t;

    state_t           r_state;
    logic [DIV_W-1:0] r_div;
    logic             r_tick;
    logic             r_wrap;
    logic             r_dir_dn;
    logic             r_mode;
    logic [W-1:0]     r_cnt;
    logic [W-1:0]     r_n1;
    logic [W-1:0]     r_n2;
    logic             r_sync1;
    logic             r_sync2;
    logic             r_prev;

    logic             w_lvl;
    logic             w_ev;
    logic [W-1:0]     w_lo;
    logic [W-1:0]     w_hi;
    logic [W-1:0]     w_ent_lo;
    logic             w_run_entry;
    logic [DIV_W-1:0] w_div_nxt;

`ifdef DEBOUNCE_EN
    localparam int unsigned      DEB_W    = $clog2(DEB_CYC + 1);
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYC - 1);

    logic             r_deb;
    logic [DEB_W-1:0] r_deb_cnt;

    // Debounced level follows sync2 only after DEB_CYC consecutive differing samples.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_deb     <= 1'b0;
            r_deb_cnt <= '0;
        end else if (r_sync2 == r_deb) begin
            r_deb_cnt <= '0;
        end else if (r_deb_cnt == DEB_LAST) begin
            r_deb     <= r_sync2;
            r_deb_cnt <= '0;
        end else begin
            r_deb_cnt <= r_deb_cnt + DEB_W'(1);
        end
    end

    assign w_lvl = r_deb;
`else
    logic w_unused_deb;
    assign w_unused_deb = (DEB_CYC != 0);
    assign w_lvl        = r_sync2;
`endif

    // Rising edge of the (optionally debounced) button level.
    assign w_ev = w_lvl & ~r_prev;

    // Bounds from the captured registers; on RUN entry N2 is taken from din_i.
    assign w_lo     = (r_n1 < r_n2) ? r_n1 : r_n2;
    assign w_hi     = (r_n1 < r_n2) ? r_n2 : r_n1;
    assign w_ent_lo = (r_n1 < din_i) ? r_n1 : din_i;

    assign w_run_entry = (r_state == S_LOAD_N2) && w_ev;

    // Divider restarts on RUN entry so the first step comes a full period later.
    assign w_div_nxt = (w_run_entry || (r_div == DIV_LAST)) ? '0 : r_div + DIV_W'(1);

    // Synchroniser, divider, load FSM and ramp.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_state  <= S_LOAD_N1;
            r_div    <= '0;
            r_tick   <= 1'b0;
            r_wrap   <= 1'b0;
            r_dir_dn <= 1'b0;
            r_mode   <= 1'b0;
            r_cnt    <= '0;
            r_n1     <= '0;
            r_n2     <= '0;
            r_sync1  <= 1'b0;
            r_sync2  <= 1'b0;
            r_prev   <= 1'b0;
        end else begin
            r_sync1 <= v_i;
            r_sync2 <= r_sync1;
            r_prev  <= w_lvl;
            r_div   <= w_div_nxt;
            r_tick  <= (w_div_nxt == DIV_LAST);
            r_wrap  <= 1'b0;
            case (r_state)
                S_LOAD_N1: begin
                    if (w_ev) begin
                        r_n1    <= din_i;
                        r_state <= S_LOAD_N2;
                    end
                end
                S_LOAD_N2: begin
                    if (w_ev) begin
                        r_n2     <= din_i;
                        r_cnt    <= w_ent_lo;
                        r_dir_dn <= 1'b0;
                        r_mode   <= mode_i;
                        r_state  <= S_RUN;
                    end
                end
                S_RUN: begin
                    // A button edge wins over a coincident tick: no step on that edge.
                    if (w_ev) begin
                        r_state <= S_HOLD;
                    end else if (r_tick) begin
                        if (w_lo == w_hi) begin
                            r_cnt  <= w_lo;
                            r_wrap <= 1'b1;
                        end else if (!r_mode) begin
                            if (r_cnt == w_hi) begin
                                r_cnt  <= w_lo;
                                r_wrap <= 1'b1;
                            end else begin
                                r_cnt <= r_cnt + W'(1);
                            end
                        end else if (!r_dir_dn) begin
                            if (r_cnt == w_hi) begin
                                r_dir_dn <= 1'b1;
                                r_cnt    <= w_hi - W'(1);
                            end else begin
                                r_cnt <= r_cnt + W'(1);
                            end
                        end else begin
                            if (r_cnt == w_lo) begin
                                r_dir_dn <= 1'b0;
                                r_cnt    <= w_lo + W'(1);
                                r_wrap   <= 1'b1;
                            end else begin
                                r_cnt <= r_cnt - W'(1);
                            end
                        end
                    end
                end
                S_HOLD: begin
                    if (w_ev) begin
                        r_state <= S_LOAD_N1;
                    end
                end
                default: r_state <= S_LOAD_N1;
            endcase
        end
    end

    assign cnt_o   = r_cnt;
    assign n1_o    = r_n1;
    assign n2_o    = r_n2;
    assign state_o = r_state;
    assign tick_o  = r_tick;
    assign wrap_o  = r_wrap;
    assign dind_o  = ((r_state == S_RUN) || (r_state == S_HOLD)) ? r_cnt : din_i;

endmodule

// File: tb/tb_ramp_counter_ctrl.sv
// Bench for ramp_counter_ctrl: vector table, directed corner sequences,
// then randomized stimulus checked every cycle against a behavioural model.
module tb_ramp_counter_ctrl;

    localparam int unsigned W   = 8;
    localparam int unsigned DIV = 4;
    localparam int unsigned DEB = 8;

    logic         clk  = 1'b0;
    logic         rst  = 1'b0;
    logic         v    = 1'b0;
    logic [W-1:0] din  = '0;
    logic         mode = 1'b0;
    logic [W-1:0] cnt, n1, n2, dind;
    logic [1:0]   st;
    logic         tick, wrap;

    ramp_counter_ctrl #(.W(W), .DIV(DIV), .DEB_CYC(DEB)) dut (
        .clk_i(clk), .rst_i(rst), .v_i(v), .din_i(din), .mode_i(mode),
        .cnt_o(cnt), .n1_o(n1), .n2_o(n2), .dind_o(dind),
        .state_o(st), .tick_o(tick), .wrap_o(wrap)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    logic chk_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    function automatic int ramp_val(int k, int lo, int hi, logic md);
        int d = hi - lo;
        int p;
        if (d == 0) return lo;
        if (!md) return lo + (k % (d + 1));
        p = k % (2 * d);
        return (p <= d) ? lo + p : lo + 2 * d - p;
    endfunction

    function automatic logic ramp_wrap(int k, int lo, int hi, logic md);
        int d = hi - lo;
        if (d == 0) return 1'b1;
        if (!md) return (k % (d + 1)) == 0;
        return (k > 1) && (((k - 1) % (2 * d)) == 0);
    endfunction

    int           m_state = 0;
    logic [W-1:0] m_n1 = '0, m_n2 = '0, m_cnt = '0;
    logic         m_mode = 1'b0, m_wrap = 1'b0, m_tick = 1'b0;
    int           m_k = 0, m_since = 0, m_lo, m_hi;
    logic [2:0]   m_h = '0;   // v_i seen at the last three edges, [0] newest
    logic         m_ev, m_tk, m_clr;

    always @(posedge clk) begin
        m_ev = m_h[1] & ~m_h[2];
        if (!rst) begin
            m_state = 0; m_n1 = '0; m_n2 = '0; m_cnt = '0; m_mode = 1'b0;
            m_wrap = 1'b0; m_tick = 1'b0; m_k = 0; m_since = 0; m_h = '0;
        end else begin
            m_tk   = m_tick;
            m_clr  = 1'b0;
            m_wrap = 1'b0;
            m_lo = (m_n1 < m_n2) ? int'(m_n1) : int'(m_n2);
            m_hi = (m_n1 < m_n2) ? int'(m_n2) : int'(m_n1);
            case (m_state)
                0: if (m_ev) begin m_n1 = din; m_state = 1; end
                1: if (m_ev) begin
                    m_n2 = din; m_mode = mode; m_k = 0; m_clr = 1'b1; m_state = 2;
                    m_cnt = (m_n1 < m_n2) ? m_n1 : m_n2;
                end
                2: if (m_ev) m_state = 3;
                   else if (m_tk) begin
                       m_k++;
                       m_cnt  = W'(ramp_val(m_k, m_lo, m_hi, m_mode));
                       m_wrap = ramp_wrap(m_k, m_lo, m_hi, m_mode);
                   end
                default: if (m_ev) m_state = 0;
            endcase
            m_since = m_clr ? 0 : m_since + 1;
            m_tick  = (m_since % DIV) == (DIV - 1);
            m_h     = {m_h[1:0], v};
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("m_state", 64'(st),   64'(m_state));
            check("m_n1",    64'(n1),   64'(m_n1));
            check("m_n2",    64'(n2),   64'(m_n2));
            check("m_cnt",   64'(cnt),  64'(m_cnt));
            check("m_wrap",  64'(wrap), 64'(m_wrap));
            check("m_tick",  64'(tick), 64'(m_tick));
            check("m_dind",  64'(dind), 64'((m_state >= 2) ? m_cnt : din));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic press(input int hi_cyc);
        v = 1'b1;
        repeat (hi_cyc) @(negedge clk);
        v = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic wait_tick();
        int budget = 3 * DIV;
        while (!tick && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        check("tick_seen", 64'(tick), 64'd1);
    endtask

    task automatic load(input logic [W-1:0] a, input logic [W-1:0] b, input logic md);
        din = a;
        #1 check("dind_ld1", 64'(dind), 64'(a));
        press(2);
        check("state_ld2", 64'(st), 64'd1);
        din = b; mode = md;
        #1 check("dind_ld2", 64'(dind), 64'(b));
        press(2);
        check("state_run", 64'(st), 64'd2);
    endtask

    typedef struct {
        logic [W-1:0] n1;
        logic [W-1:0] n2;
        logic         md;
        logic [47:0]  seq;   // cnt after steps k0..k5, k0 in the top byte
        logic [5:0]   wr;    // wrap after steps k0..k5, k0 in the top bit
    } vec_t;

    vec_t vt[8];

    initial begin
        int rec, hold_cnt, t_prev, chg, j;
        vt[0] = '{8'h03, 8'h06, 1'b0, 48'h03_04_05_06_03_04, 6'b000010};
        vt[1] = '{8'h09, 8'h07, 1'b1, 48'h07_08_09_08_07_08, 6'b000001};
        vt[2] = '{8'h05, 8'h05, 1'b0, 48'h05_05_05_05_05_05, 6'b011111};
        vt[3] = '{8'h05, 8'h05, 1'b1, 48'h05_05_05_05_05_05, 6'b011111};
        vt[4] = '{8'h02, 8'h03, 1'b1, 48'h02_03_02_03_02_03, 6'b000101};
        vt[5] = '{8'hFF, 8'hFE, 1'b0, 48'hFE_FF_FE_FF_FE_FF, 6'b001010};
        vt[6] = '{8'h00, 8'hFF, 1'b1, 48'h00_01_02_03_04_05, 6'b000000};
        vt[7] = '{8'hFF, 8'h00, 1'b0, 48'h00_01_02_03_04_05, 6'b000000};

        repeat (2) @(negedge clk);
        check("rst_state", 64'(st),   64'd0);
        check("rst_cnt",   64'(cnt),  64'd0);
        check("rst_n1",    64'(n1),   64'd0);
        check("rst_n2",    64'(n2),   64'd0);
        check("rst_wrap",  64'(wrap), 64'd0);
        check("rst_tick",  64'(tick), 64'd0);
`ifndef DEBOUNCE_EN
        chk_en = 1'b1;
`endif
        rst = 1'b1;
        @(negedge clk);

`ifdef DEBOUNCE_EN
        v = 1'b1;
        repeat (5) @(negedge clk);
        v = 1'b0;
        repeat (30) @(negedge clk);
        check("deb_glitch", 64'(st), 64'd0);
        v = 1'b1;
        j = 0;
        while (st == 2'd0 && j < 40) begin
            @(negedge clk);
            j++;
        end
        check("deb_latency", 64'(j), 64'd11);
        if (j < 20) repeat (20 - j) @(negedge clk);
        v = 1'b0;
        repeat (40) @(negedge clk);
        check("deb_once", 64'(st), 64'd1);
`else
        // Table: load, step through six ramp values, then hold and release.
        for (int i = 0; i < 8; i++) begin
            load(vt[i].n1, vt[i].n2, vt[i].md);
            check("vec_n1",  64'(n1),   64'(vt[i].n1));
            check("vec_n2",  64'(n2),   64'(vt[i].n2));
            check("vec_k0",  64'(cnt),  64'(vt[i].seq[40 +: 8]));
            check("vec_w0",  64'(wrap), 64'd0);
            check("vec_dind", 64'(dind), 64'(cnt));
            t_prev = 0;
            for (int k = 1; k < 6; k++) begin
                wait_tick();
                if (k > 1) check("tick_period", 64'(cyc - t_prev), 64'(DIV));
                t_prev = cyc;
                @(negedge clk);
                check("vec_cnt",  64'(cnt),  64'(vt[i].seq[8 * (5 - k) +: 8]));
                check("vec_wrap", 64'(wrap), 64'(vt[i].wr[5 - k]));
            end
            press(2);
            check("hold_state", 64'(st), 64'd3);
            rec = int'(cnt);
            chg = 0;
            repeat (12) begin
                @(negedge clk);
                if (int'(cnt) != rec || wrap) chg++;
            end
            check("hold_frozen", 64'(chg), 64'd0);
            press(2);
            check("back_ld1",   64'(st),  64'd0);
            check("kept_cnt",   64'(cnt), 64'(rec));
            check("kept_n1",    64'(n1),  64'(vt[i].n1));
        end

        // Button edge lands on the same clock edge as a tick.
        load(8'h03, 8'h06, 1'b0);
        wait_tick();
        @(negedge clk);
        @(negedge clk);
        v = 1'b1;
        rec = int'(cnt);
        @(negedge clk);
        @(negedge clk);
        v = 1'b0;
        check("coll_tick", 64'(tick), 64'd1);
        @(negedge clk);
        check("coll_state", 64'(st),  64'd3);
        check("coll_cnt",   64'(cnt), 64'(rec));
        repeat (3) @(negedge clk);
        press(2);
        check("coll_ld1", 64'(st), 64'd0);

        // Reset in the middle of RUN.
        load(8'h01, 8'h04, 1'b1);
        repeat (9) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("mrst_state", 64'(st),   64'd0);
        check("mrst_cnt",   64'(cnt),  64'd0);
        check("mrst_n1",    64'(n1),   64'd0);
        check("mrst_n2",    64'(n2),   64'd0);
        check("mrst_wrap",  64'(wrap), 64'd0);
        check("mrst_tick",  64'(tick), 64'd0);
        rst = 1'b1;

        // Randomized traffic; the model checker compares every cycle.
        hold_cnt = 0;
        for (int c = 0; c < 6000; c++) begin
            @(negedge clk);
            if (hold_cnt == 0) begin
                v = ~v;
                hold_cnt = int'($urandom_range(1, 30));
            end else begin
                hold_cnt--;
            end
            din = W'($urandom);
            if ($urandom_range(0, 15) == 0) mode = 1'($urandom);
            rst = ($urandom_range(0, 799) != 0);
        end
        rst = 1'b1;
        repeat (2) @(negedge clk);
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
